mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: bus-fault timeout in cycles; 0 disables timeout.
REQ-002 Parameter ERR_RDATA, default 32'hDEADBEEF: read data returned on a timed-out transfer.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_valid/m0_addr/m0_wdata/m0_wstrb  in  1/32/32/4  master 0 (CPU) request, picorv32 memory-bus semantics.
REQ-006 m0_ready/m0_rdata  out  1/32  master 0 completion and read data.
REQ-007 m1_valid/m1_addr/m1_wdata/m1_wstrb  in  1/32/32/4  master 1 (DMA/debug) request.
REQ-008 m1_ready/m1_rdata  out  1/32  master 1 completion and read data.
REQ-009 s_valid/s_addr/s_wdata/s_wstrb  out  1/32/32/4  shared slave bus to the address decoder.
REQ-010 s_ready/s_rdata  in  1/32  OR-ed slave ready and muxed slave read data.
REQ-011 grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle.
REQ-012 err  out  1  sticky bus-fault flag.
REQ-013 err_addr  out  32  address of the first timed-out transfer since the last clear.
REQ-014 err_clr  in  1  single-cycle pulse that clears err.

Function
REQ-015 FSM states IDLE, GNT0, GNT1; grant = 2'b00, 2'b01, 2'b10 respectively.
REQ-016 IDLE: m0_valid only -> GNT0; m1_valid only -> GNT1; both -> the master not in last_owner; neither -> stay in IDLE.
REQ-017 last_owner register updates to the granted master on every IDLE->GNTx transition.
REQ-018 Arbitration latency is exactly 1 cycle: a request seen in IDLE drives s_valid on the next cycle.
REQ-019 GNTx: s_valid=1; s_addr, s_wdata and s_wstrb combinationally equal the granted master's signals.
REQ-020 IDLE: s_valid=0, s_wstrb=0; s_addr/s_wdata are don't-care.
REQ-021 GNTx: mx_ready = s_ready | timeout_hit (combinational); mx_rdata = timeout_hit ? ERR_RDATA : s_rdata.
REQ-022 Non-granted master: ready=0, rdata=0 in all cases.
REQ-023 Completion cycle (mx_ready=1) -> IDLE next cycle; no back-to-back grants, so there is one idle cycle between transfers.
REQ-024 Masters hold valid and payload stable until ready; the arbiter does not check this; a dropped valid in GNTx is ignored.
REQ-025 The grant is never preempted: a higher-priority or other request waits until the current transfer completes.
REQ-026 Timeout counter, 16 bits: cleared on IDLE->GNTx, incremented each GNTx cycle with s_ready=0.
REQ-027 timeout_hit = (TIMEOUT_CYCLES != 0) & ~s_ready & (count == TIMEOUT_CYCLES-1).
REQ-028 When s_ready and the timeout fire in the same cycle, s_ready wins: normal completion, no error.
REQ-029 On timeout_hit, err is set next cycle; err_addr captures s_addr only if err was 0.
REQ-030 err_clr clears err; if err_clr and timeout_hit occur together, set wins and err_addr is updated.
REQ-031 A write that times out is dropped silently apart from err; no retry is performed.

Reset
REQ-032 Reset, held for 1 or more cycles, forces state=IDLE, last_owner=m1 (so m0 wins the first tie), count=0, err=0, err_addr=0.
REQ-033 While reset is high: s_valid=0, m0_ready=m1_ready=0, grant=0.
REQ-034 Reset asserted mid-transfer abandons the transfer: no ready is issued to either master.

Verification
REQ-035 m0 and m1 both read at 0x100/0x200, slave ready after 2 cycles -> grant sequence 01,00,10; m0 completes first, then m1.
REQ-036 m1 requests continuously and m0 requests once -> m0 granted in the next arbitration; m1 is not granted twice in a row while m0 waits.
REQ-037 TIMEOUT_CYCLES=4, m0 read 0x9000_0000, s_ready never asserted -> m0_ready pulses in the 4th GNT0 cycle with m0_rdata=DEADBEEF; next cycle err=1, err_addr=0x9000_0000.
REQ-038 Second timeout at 0x9000_0004 while err=1 -> err_addr stays 0x9000_0000; err_clr pulse -> err=0.
REQ-039 s_ready in exactly the timeout cycle with s_rdata=0x1234 -> m0_rdata=0x1234, err stays 0.
REQ-040 Reset asserted while in GNT1 -> IDLE on the next cycle, m1_ready never asserted, err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a picorv32-style memory bus: alternating priority on ties,
// no preemption, and a bus-fault timeout that completes a stalled transfer with error data.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam bit          LP_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] LP_LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_lastOwner;
  logic [15:0] r_count;
  logic        r_err;
  logic [31:0] r_errAddr;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_timeoutHit;
  logic        w_done;

  // Reset masks the grant combinationally so nothing completes while it is held.
  assign w_gnt0       = (r_state == GNT0) & ~reset;
  assign w_gnt1       = (r_state == GNT1) & ~reset;
  assign w_timeoutHit = LP_TIMEOUT_EN & (w_gnt0 | w_gnt1) & ~s_ready & (r_count == LP_LAST_COUNT);
  assign w_done       = (w_gnt0 | w_gnt1) & (s_ready | w_timeoutHit);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // r_lastOwner = 1 means m1 was granted last, so m0 wins the next tie.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (m0_valid && m1_valid) w_nextState = r_lastOwner ? GNT0 : GNT1;
        else if (m0_valid)        w_nextState = GNT0;
        else if (m1_valid)        w_nextState = GNT1;
        else                      w_nextState = IDLE;
      end
      GNT0, GNT1: if (w_done) w_nextState = IDLE;
      default:    w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastOwner <= 1'b1;
      r_count     <= '0;
    end else begin
      if (r_state == IDLE && w_nextState != IDLE) r_lastOwner <= (w_nextState == GNT1);
      if (r_state == IDLE)  r_count <= '0;
      else if (!s_ready)    r_count <= r_count + 16'd1;
    end
  end

  // A simultaneous clear and new fault behaves as clear-then-set, so the address is recaptured.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err     <= 1'b0;
      r_errAddr <= '0;
    end else if (w_timeoutHit) begin
      r_err <= 1'b1;
      if (!r_err || err_clr) r_errAddr <= s_addr;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  always_comb begin
    grant    = {w_gnt1, w_gnt0};
    s_valid  = w_gnt0 | w_gnt1;
    s_addr   = (r_state == GNT1) ? m1_addr  : m0_addr;
    s_wdata  = (r_state == GNT1) ? m1_wdata : m0_wdata;
    s_wstrb  = w_gnt0 ? m0_wstrb : (w_gnt1 ? m1_wstrb : 4'b0000);
    m0_ready = w_gnt0 & w_done;
    m1_ready = w_gnt1 & w_done;
    m0_rdata = '0;
    m1_rdata = '0;
    if (w_gnt0) m0_rdata = w_timeoutHit ? ERR_RDATA : s_rdata;
    if (w_gnt1) m1_rdata = w_timeoutHit ? ERR_RDATA : s_rdata;
    err      = r_err;
    err_addr = r_errAddr;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed bus scenarios then randomized traffic, every cycle
// compared against a transaction-level model of ownership, timeouts and the error flag.
module tb_mem_arbiter;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid, s_ready, err_clr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready, s_valid, err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, err_addr;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  // Model: owner 0 = nobody, 1 = m0, 2 = m1; elapsed = cycles already spent waiting in the grant.
  int          mOwner   = 0;
  int          mLast    = 2;
  int          mElapsed = 0;
  bit          mErr     = 1'b0;
  logic [31:0] mErrAddr = '0;
  bit          m0Done, m1Done;
  bit          p0, p1;

  mem_arbiter #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .err(err), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares one cycle against the model, advances the model, then moves just past the next edge.
  task automatic applyStimulus();
    bit          inG, hit, done;
    int          nxt;
    logic [31:0] eAddr, eWdata, eR0, eR1;
    logic [3:0]  eStrb;
    #2;
    inG    = (mOwner != 0) && !reset;
    hit    = inG && !s_ready && (mElapsed == T - 1);
    done   = inG && (s_ready || hit);
    eAddr  = (mOwner == 2) ? m1_addr  : m0_addr;
    eWdata = (mOwner == 2) ? m1_wdata : m0_wdata;
    eStrb  = inG ? ((mOwner == 2) ? m1_wstrb : m0_wstrb) : 4'b0000;
    eR0    = (inG && mOwner == 1) ? (hit ? ERR : s_rdata) : 32'h0;
    eR1    = (inG && mOwner == 2) ? (hit ? ERR : s_rdata) : 32'h0;
    checkOutput("grant",    32'(grant),    inG ? 32'(mOwner) : 32'h0);
    checkOutput("s_valid",  32'(s_valid),  32'(inG));
    checkOutput("s_wstrb",  32'(s_wstrb),  32'(eStrb));
    if (inG) begin
      checkOutput("s_addr",  s_addr,  eAddr);
      checkOutput("s_wdata", s_wdata, eWdata);
    end
    checkOutput("m0_ready", 32'(m0_ready), 32'(done && mOwner == 1));
    checkOutput("m1_ready", 32'(m1_ready), 32'(done && mOwner == 2));
    checkOutput("m0_rdata", m0_rdata, eR0);
    checkOutput("m1_rdata", m1_rdata, eR1);
    checkOutput("err",      32'(err),      32'(mErr));
    checkOutput("err_addr", err_addr, mErrAddr);
    m0Done = done && mOwner == 1;
    m1Done = done && mOwner == 2;
    if (reset) begin
      mOwner = 0; mLast = 2; mElapsed = 0; mErr = 1'b0; mErrAddr = '0;
    end else begin
      if (hit) begin
        if (!mErr || err_clr) mErrAddr = eAddr;
        mErr = 1'b1;
      end else if (err_clr) mErr = 1'b0;
      if (mOwner == 0) begin
        if (m0_valid && m1_valid) nxt = (mLast == 2) ? 1 : 2;
        else if (m0_valid)        nxt = 1;
        else if (m1_valid)        nxt = 2;
        else                      nxt = 0;
        if (nxt != 0) begin mLast = nxt; mElapsed = 0; end
        mOwner = nxt;
      end else if (done) mOwner = 0;
      else mElapsed++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; err_clr = 1'b0; s_ready = 1'b0; s_rdata = '0;
    m0_valid = 1'b1; m0_addr = 32'h80; m0_wdata = '0; m0_wstrb = 4'hF;
    m1_valid = 1'b0; m1_addr = '0;    m1_wdata = '0; m1_wstrb = '0;
    @(posedge clk);
    #1;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_err",   32'(err),   32'h0);
    reset = 1'b0; m0_valid = 1'b0; m0_wstrb = 4'h0;
    applyStimulus();

    // Simultaneous reads: m0 wins the first tie, one idle cycle, then m1.
    m0_valid = 1'b1; m0_addr = 32'h100;
    m1_valid = 1'b1; m1_addr = 32'h200;
    applyStimulus();
    checkOutput("tie_g0", 32'(grant), 32'h1);
    applyStimulus();
    s_ready = 1'b1; s_rdata = 32'hAAAA_0001;
    applyStimulus();
    m0_valid = 1'b0; s_ready = 1'b0;
    checkOutput("tie_idle", 32'(grant), 32'h0);
    applyStimulus();
    checkOutput("tie_g1", 32'(grant), 32'h2);
    applyStimulus();
    s_ready = 1'b1; s_rdata = 32'hBBBB_0002;
    applyStimulus();
    m1_valid = 1'b0; s_ready = 1'b0;
    checkOutput("tie_idle2", 32'(grant), 32'h0);
    applyStimulus();

    // m1 streams, m0 asks once: m0 must take the next arbitration.
    m1_valid = 1'b1; m1_addr = 32'h300; s_ready = 1'b1; s_rdata = 32'h33;
    applyStimulus();
    m0_valid = 1'b1; m0_addr = 32'h400;
    applyStimulus();
    applyStimulus();
    checkOutput("fair_m0", 32'(grant), 32'h1);
    applyStimulus();
    m0_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    m1_valid = 1'b0; s_ready = 1'b0;
    applyStimulus();

    // Timeout on an unresponsive slave.
    m0_valid = 1'b1; m0_addr = 32'h9000_0000;
    applyStimulus();
    applyStimulus(); applyStimulus(); applyStimulus();
    #1;
    checkOutput("to_ready", 32'(m0_ready), 32'h1);
    checkOutput("to_rdata", m0_rdata, ERR);
    applyStimulus();
    m0_valid = 1'b0;
    checkOutput("to_err",  32'(err), 32'h1);
    checkOutput("to_addr", err_addr, 32'h9000_0000);

    // Second timeout keeps the first address; then clear.
    m0_valid = 1'b1; m0_addr = 32'h9000_0004;
    applyStimulus();
    repeat (4) applyStimulus();
    m0_valid = 1'b0;
    checkOutput("to2_addr", err_addr, 32'h9000_0000);
    err_clr = 1'b1;
    applyStimulus();
    err_clr = 1'b0;
    checkOutput("clr_err", 32'(err), 32'h0);

    // s_ready arriving in the timeout cycle wins.
    m0_valid = 1'b1; m0_addr = 32'h500;
    applyStimulus();
    repeat (3) applyStimulus();
    s_ready = 1'b1; s_rdata = 32'h1234;
    #1;
    checkOutput("race_rdata", m0_rdata, 32'h1234);
    applyStimulus();
    s_ready = 1'b0; m0_valid = 1'b0;
    checkOutput("race_err", 32'(err), 32'h0);

    // Reset in the middle of an m1 transfer.
    m1_valid = 1'b1; m1_addr = 32'h600;
    applyStimulus();
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0; m1_valid = 1'b0;
    checkOutput("midrst_grant", 32'(grant), 32'h0);
    checkOutput("midrst_err",   32'(err),   32'h0);
    applyStimulus();

    // Randomized traffic from protocol-abiding masters.
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; m0_valid = 1'b1;
        m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; m1_valid = 1'b1;
        m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      end
      s_ready = ($urandom_range(0, 3) == 0);
      s_rdata = $urandom;
      err_clr = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 59) == 0);
      applyStimulus();
      if (m0Done) begin p0 = 1'b0; m0_valid = 1'b0; end
      if (m1Done) begin p1 = 1'b0; m1_valid = 1'b0; end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
